// File: rtl/fpu_core_arbiter.sv
// Merges NB_CORES core-side FPU ports onto one shared FPU with round-robin selection,
// grant lock while the FPU stalls, and an in-order ID FIFO to route responses back.
//
// state  | meaning
// IDLE   | round-robin choice each cycle starting after the last served core
// LOCKED | FPU stalled an offered request; keep presenting the same core until granted
module fpu_core_arbiter #(
   parameter int NB_CORES        = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int NB_ARGS         = 3,
   parameter int OPCODE_WIDTH    = 6,
   parameter int DSFLAGS_CPU     = 15,
   parameter int USFLAGS_CPU     = 5,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NB_CORES-1:0]                     core_req_i,
   output logic [NB_CORES-1:0]                     core_gnt_o,
   input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0]  core_operands_i,
   input  logic [NB_CORES*OPCODE_WIDTH-1:0]        core_op_i,
   input  logic [NB_CORES*DSFLAGS_CPU-1:0]         core_flags_i,
   input  logic [NB_CORES-1:0]                     core_rready_i,
   output logic [NB_CORES-1:0]                     core_rvalid_o,
   output logic [DATA_WIDTH-1:0]                   core_rdata_o,
   output logic [USFLAGS_CPU-1:0]                  core_rflags_o,
   output logic                                    fpu_req_o,
   input  logic                                    fpu_gnt_i,
   output logic [NB_ARGS*DATA_WIDTH-1:0]           fpu_operands_o,
   output logic [OPCODE_WIDTH-1:0]                 fpu_op_o,
   output logic [DSFLAGS_CPU-1:0]                  fpu_flags_o,
   output logic                                    fpu_rready_o,
   input  logic                                    fpu_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                   fpu_rdata_i,
   input  logic [USFLAGS_CPU-1:0]                  fpu_rflags_i,
   output logic [$clog2(MAX_OUTSTANDING):0]        outstanding_o,
   output logic                                    resp_err_o
);

   localparam int CW  = $clog2(NB_CORES);
   localparam int PW  = $clog2(MAX_OUTSTANDING);
   localparam int OPW = NB_ARGS * DATA_WIDTH;
   localparam logic [CW-1:0] LAST_RST = CW'(NB_CORES - 1);
   localparam logic [PW:0]   CNT_MAX  = (PW+1)'(MAX_OUTSTANDING);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] last_q, lock_id_q, lock_id_d;
   logic [CW-1:0] rr_winner, cand, winner, head;
   logic          rr_found, req_ok;
   logic [CW-1:0] id_mem [MAX_OUTSTANDING];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic          fifo_full, fifo_empty, push, pop, resp_err_q;

   always_comb begin
      rr_winner = '0;
      rr_found  = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NB_CORES; i++) begin
         cand = CW'((int'(last_q) + i) % NB_CORES);
         if (!rr_found && core_req_i[cand]) begin
            rr_winner = cand;
            rr_found  = 1'b1;
         end
      end
   end

   // While locked, only the held core's request counts, so a dropped request cannot
   // hand a grant to some other core through the held selection.
   assign winner     = (state_q == LOCKED) ? lock_id_q : rr_winner;
   assign req_ok     = (state_q == LOCKED) ? core_req_i[lock_id_q] : |core_req_i;
   assign fifo_full  = (count_q == CNT_MAX);
   assign fifo_empty = (count_q == '0);
   assign fpu_req_o  = req_ok & ~fifo_full & ~rst;
   assign push       = fpu_req_o & fpu_gnt_i;

   always_comb begin
      core_gnt_o         = '0;
      core_gnt_o[winner] = push;
   end

   assign fpu_operands_o = core_operands_i[int'(winner)*OPW +: OPW];
   assign fpu_op_o       = core_op_i[int'(winner)*OPCODE_WIDTH +: OPCODE_WIDTH];
   assign fpu_flags_o    = core_flags_i[int'(winner)*DSFLAGS_CPU +: DSFLAGS_CPU];

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      case (state_q)
         IDLE: begin
            if (fpu_req_o && !fpu_gnt_i) begin
               state_d   = LOCKED;
               lock_id_d = winner;
            end
         end
         LOCKED: begin
            if (!core_req_i[lock_id_q] || push) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign head = id_mem[rd_ptr_q];

   always_comb begin
      core_rvalid_o       = '0;
      core_rvalid_o[head] = fpu_rvalid_i & ~fifo_empty & ~rst;
   end

   assign fpu_rready_o  = core_rready_i[head] & ~fifo_empty & ~rst;
   assign pop           = fpu_rvalid_i & fpu_rready_o;
   assign core_rdata_o  = fpu_rdata_i;
   assign core_rflags_o = fpu_rflags_i;
   assign outstanding_o = count_q;
   assign resp_err_o    = resp_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         lock_id_q  <= '0;
         last_q     <= LAST_RST;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         resp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_id_q  <= lock_id_d;
         resp_err_q <= fpu_rvalid_i & fifo_empty;
         if (push) begin
            last_q   <= winner;
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // ID storage needs no reset: entries are only read behind a nonzero count.
   always_ff @(posedge clk) begin
      if (push) id_mem[wr_ptr_q] <= winner;
   end

endmodule
